pulse_event_accumulator: RTL and testbench

//  Destination-domain stage fed by the pulse synchronizer's pulse_b output.

---
 rtl/pulse_event_accumulator.sv | 160 ++++++++++++++++
 tb/tb_pulse_event_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_accumulator.sv
// -----------------------------------------------------------------------------
// pulse_event_accumulator
//
// Purpose:
//   This stage sits in the destination clock domain and is driven by the pulse
//   synchronizer output. It counts one-cycle event pulses and groups them into
//   count reports. A report is launched when the batch reaches THRESH events,
//   or when TIMEOUT cycles have passed since the first pulse of the batch.
//   Pulses that arrive while a report waits for the consumer are still counted
//   in the live accumulator, so backpressure loses no events. An event is lost
//   only when the accumulator is saturated. That case sets the sticky overflow
//   flag.
//
// Ports:
//   clk_b        in   1      destination clock; all logic uses its rising edge
//   n_rst_b      in   1      asynchronous, active-low reset
//   pulse_in     in   1      one-cycle event pulse
//   clear        in   1      synchronous flush of all state, including a pending report
//   count_valid  out  1      report available
//   count_ready  in   1      consumer accepts the report
//   count_data   out  CNT_W  number of events in the report
//   overflow     out  1      sticky; an event was lost to saturation
//   dbg_state_o  out  2      current FSM state (0 IDLE, 1 ACCUM, 2 REPORT)
//   dbg_acc_o    out  CNT_W  live accumulator value
//
// Handshake:
//   count_valid/count_ready use strict valid/ready rules. A report transfers on
//   every rising edge where count_valid and count_ready are both high. While
//   count_valid is high and no transfer has happened, count_valid and
//   count_data hold steady. The one exception is clear, which withdraws the
//   report. count_valid does not depend on count_ready.
// -----------------------------------------------------------------------------
module pulse_event_accumulator #(
    parameter int CNT_W   = 8,
    parameter int THRESH  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_b,
    input  logic             n_rst_b,
    input  logic             pulse_in,
    input  logic             clear,
    output logic             count_valid,
    input  logic             count_ready,
    output logic [CNT_W-1:0] count_data,
    output logic             overflow,
    output logic [1:0]       dbg_state_o,
    output logic [CNT_W-1:0] dbg_acc_o
);

    localparam int               TW     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] snap_q;
    logic [TW-1:0]    timer_q;
    logic             valid_q;
    logic             overflow_q;

    logic [CNT_W-1:0] nacc_d;
    logic             sat_d;
    logic             launch_d;
    logic             xfer_d;

    // Next accumulator value, including this cycle's pulse. At full scale the
    // value saturates and the pulse is recorded as lost.
    always_comb begin
        sat_d    = pulse_in && (acc_q == CNT_MAX);
        nacc_d   = (pulse_in && !sat_d) ? acc_q + 1'b1 : acc_q;
        // A report can launch only from IDLE or ACCUM. The timeout applies only
        // once a batch has started, which is the ACCUM state.
        launch_d = (state_q != REPORT) &&
                   ((nacc_d >= THR) || ((state_q == ACCUM) && (timer_q == T_LAST)));
        xfer_d   = valid_q && count_ready;
    end

    always_ff @(posedge clk_b or negedge n_rst_b) begin
        if (!n_rst_b) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            snap_q     <= '0;
            timer_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            // Flush everything. A pulse arriving in the same cycle is discarded.
            state_q    <= IDLE;
            acc_q      <= '0;
            snap_q     <= '0;
            timer_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (sat_d) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE, ACCUM: begin
                    if (launch_d) begin
                        // The snapshot includes this cycle's pulse. The live
                        // count restarts from zero.
                        snap_q  <= nacc_d;
                        acc_q   <= '0;
                        timer_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= REPORT;
                    end else if (state_q == IDLE) begin
                        if (pulse_in) begin
                            acc_q   <= nacc_d;
                            timer_q <= '0;
                            state_q <= ACCUM;
                        end
                    end else begin
                        acc_q   <= nacc_d;
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (xfer_d) begin
                        valid_q <= 1'b0;
                        // Events gathered during the wait start a new batch.
                        // If that batch is already at threshold, it relaunches
                        // from ACCUM on the next cycle.
                        if (nacc_d != '0) begin
                            acc_q   <= nacc_d;
                            timer_q <= '0;
                            state_q <= ACCUM;
                        end else begin
                            acc_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        acc_q <= nacc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    timer_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign count_valid = valid_q;
    assign count_data  = snap_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;
    assign dbg_acc_o   = acc_q;

endmodule

// File: tb/tb_pulse_event_accumulator.sv
// -----------------------------------------------------------------------------
// tb_pulse_event_accumulator
//
// Directed bench for pulse_event_accumulator with the default parameters
// (CNT_W=8, THRESH=16, TIMEOUT=64). Each scenario pushes the report values it
// expects into exp_q. A monitor running on the falling edge pops from exp_q on
// every accepted report. It also checks that a pending report keeps valid high
// and its data steady until it is accepted. The bench ends with a random phase
// that checks event conservation.
// -----------------------------------------------------------------------------
module tb_pulse_event_accumulator;

    localparam int CNT_W = 8;

    logic             clk_b = 1'b0;
    logic             n_rst_b = 1'b0;
    logic             pulse_in = 1'b0;
    logic             clear = 1'b0;
    logic             count_ready = 1'b0;
    logic             count_valid;
    logic [CNT_W-1:0] count_data;
    logic             overflow;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_acc;

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_v;
    logic             rand_mode = 1'b0;
    int               xfer_sum = 0;

    logic             prev_valid = 1'b0;
    logic             prev_xfer  = 1'b0;
    logic             prev_clear = 1'b0;
    logic [CNT_W-1:0] prev_data  = '0;

    pulse_event_accumulator #(
        .CNT_W  (CNT_W),
        .THRESH (16),
        .TIMEOUT(64)
    ) dut (
        .clk_b      (clk_b),
        .n_rst_b    (n_rst_b),
        .pulse_in   (pulse_in),
        .clear      (clear),
        .count_valid(count_valid),
        .count_ready(count_ready),
        .count_data (count_data),
        .overflow   (overflow),
        .dbg_state_o(dbg_state),
        .dbg_acc_o  (dbg_acc)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_b = ~clk_b;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle. On return we are 1 time unit after the next
    // rising edge.
    task automatic cyc(input logic p, input logic r);
        pulse_in    = p;
        count_ready = r;
        @(posedge clk_b);
        #1;
    endtask

    // Advance cycles with no pulses until count_valid is high, up to budget.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!count_valid && n < budget) begin
            cyc(1'b0, count_ready);
            n++;
        end
        if (!count_valid) chk("valid_timeout", count_valid, 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_b) begin
        if (!n_rst_b) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_clear = 1'b0;
        end else begin
            if (prev_valid && !prev_xfer && !prev_clear) begin
                chk("valid_held", count_valid, 1);
                chk("data_stable", count_data, prev_data);
            end
            if (count_valid && count_ready && !clear) begin
                xfer_sum += count_data;
                if (!rand_mode) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_report: got %0d expected none", count_data);
                    end else begin
                        exp_v = exp_q.pop_front();
                        chk("report_data", count_data, exp_v);
                    end
                end
            end
            prev_valid = count_valid;
            prev_data  = count_data;
            prev_xfer  = count_valid && count_ready && !clear;
            prev_clear = clear;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int pulses;
        int d;
        logic p;
        logic r;

        // Reset values
        repeat (3) @(posedge clk_b);
        #1;
        chk("rst_valid", count_valid, 0);
        chk("rst_data", count_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_acc", dbg_acc, 0);
        n_rst_b = 1'b1;
        cyc(1'b0, 1'b0);

        // Threshold: pulses in cycles 0..15 with ready=1. Report valid in cycle 16.
        exp_q.push_back(8'd16);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1);
            if (k == 14) chk("thresh_not_early", count_valid, 0);
        end
        chk("thresh_valid", count_valid, 1);
        chk("thresh_data", count_data, 16);
        chk("thresh_state", dbg_state, 2);
        cyc(1'b0, 1'b1);
        chk("thresh_valid_drop", count_valid, 0);
        chk("thresh_idle", dbg_state, 0);

        // Timeout: pulses at 0, 10 and 20. Report valid in cycle 65 with data 3.
        exp_q.push_back(8'd3);
        for (int k = 0; k < 64; k++) cyc((k == 0 || k == 10 || k == 20), 1'b1);
        chk("timeout_not_early", count_valid, 0);
        cyc(1'b0, 1'b1);
        chk("timeout_valid", count_valid, 1);
        chk("timeout_data", count_data, 3);
        cyc(1'b0, 1'b1);
        chk("timeout_acc_after", dbg_acc, 0);
        chk("timeout_idle", dbg_state, 0);

        // Backpressure: 20 pulses with ready=0, then ready=1 in cycle 30.
        exp_q.push_back(8'd16);
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0);
        chk("bp_valid", count_valid, 1);
        chk("bp_data", count_data, 16);
        chk("bp_acc", dbg_acc, 4);
        exp_q.push_back(8'd4);
        cyc(1'b0, 1'b1);
        chk("bp_state_accum", dbg_state, 1);
        chk("bp_acc_kept", dbg_acc, 4);
        chk("bp_valid_drop", count_valid, 0);
        wait_valid(100, n);
        chk("bp_timeout_cycles", n, 64);
        chk("bp_data2", count_data, 4);
        cyc(1'b0, 1'b1);
        chk("bp_idle", dbg_state, 0);

        // Relaunch: 24 events wait behind the report, then launch again after one bubble cycle.
        exp_q.push_back(8'd16);
        exp_q.push_back(8'd24);
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0);
        chk("rl_acc", dbg_acc, 24);
        cyc(1'b0, 1'b1);
        chk("rl_bubble", count_valid, 0);
        chk("rl_state", dbg_state, 1);
        cyc(1'b0, 1'b1);
        chk("rl_valid", count_valid, 1);
        chk("rl_data", count_data, 24);
        chk("rl_acc0", dbg_acc, 0);
        cyc(1'b0, 1'b1);
        chk("rl_idle", dbg_state, 0);

        // Simultaneous pulse and transfer with acc=0.
        exp_q.push_back(8'd16);
        exp_q.push_back(8'd1);
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0);
        chk("sim_valid", count_valid, 1);
        chk("sim_acc0", dbg_acc, 0);
        cyc(1'b1, 1'b1);
        chk("sim_state", dbg_state, 1);
        chk("sim_acc1", dbg_acc, 1);
        wait_valid(100, n);
        chk("sim_timeout_cycles", n, 64);
        cyc(1'b0, 1'b1);
        chk("sim_idle", dbg_state, 0);

        // Saturation: 300 pulses with ready=0, then clear with a pulse in the same cycle.
        exp_q.push_back(8'd16);
        for (int k = 0; k < 300; k++) cyc(1'b1, 1'b0);
        chk("sat_data", count_data, 16);
        chk("sat_acc", dbg_acc, 255);
        chk("sat_ovf", overflow, 1);
        exp_q.delete();
        clear = 1'b1;
        cyc(1'b1, 1'b0);
        clear = 1'b0;
        chk("clr_valid", count_valid, 0);
        chk("clr_data", count_data, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_acc", dbg_acc, 0);
        chk("clr_state", dbg_state, 0);
        cyc(1'b0, 1'b0);
        chk("clr_pulse_dropped", dbg_acc, 0);

        // Asynchronous reset while a report is pending.
        exp_q.push_back(8'd16);
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0);
        chk("ar_valid_before", count_valid, 1);
        pulse_in = 1'b0;
        #1;
        n_rst_b = 1'b0;
        #1;
        chk("ar_valid", count_valid, 0);
        chk("ar_data", count_data, 0);
        chk("ar_state", dbg_state, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_b);
        #1;
        n_rst_b = 1'b1;
        cyc(1'b0, 1'b0);
        chk("ar_idle", dbg_state, 0);
        chk("ar_acc", dbg_acc, 0);

        // Random conservation: all events must come out in transferred reports.
        rand_mode = 1'b1;
        xfer_sum  = 0;
        pulses    = 0;
        for (int i = 0; i < 4000; i++) begin
            p = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            pulses += int'(p);
            cyc(p, r);
        end
        d = 0;
        while ((dbg_state != 2'd0 || count_valid) && d < 300) begin
            cyc(1'b0, 1'b1);
            d++;
        end
        chk("drain_idle", dbg_state, 0);
        chk("conservation", xfer_sum, pulses);
        chk("rand_ovf", overflow, 0);
        rand_mode = 1'b0;

        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
